// File: rtl/controlador_multiplicador_display_if.sv
// -----------------------------------------------------------------------------
// controlador_multiplicador_display_if
// Purpose : bundles the request/result and display signals of the x3
//           multiplier / 4-digit 7-segment display controller.
// Signals : load    - start request (master -> slave)
//           a_in    - 5-bit operand, sampled with load (master -> slave)
//           ready   - controller idle (slave -> master)
//           done    - one-cycle pulse when new digits are latched
//           product - registered A*FACTOR, 7 bits
//           seg     - segments {a,b,c,d,e,f,g}, active-high
//           an      - one-hot digit enable, active-high
// Modports: master (drives requests), slave (the controller).
// -----------------------------------------------------------------------------
interface controlador_multiplicador_display_if;
    logic       load;
    logic [4:0] a_in;
    logic       ready;
    logic       done;
    logic [6:0] product;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (
        output load, a_in,
        input  ready, done, product, seg, an
    );

    modport slave (
        input  load, a_in,
        output ready, done, product, seg, an
    );
endinterface

// File: rtl/controlador_multiplicador_display.sv
// -----------------------------------------------------------------------------
// controlador_multiplicador_display
// Purpose : captures a 5-bit operand A on load, computes P = A*FACTOR by
//           repeated addition, converts A and P to BCD with a serial
//           double-dabble, latches four digit codes and time-multiplexes
//           them onto one shared segment bus (digits 1-2 = A, 3-4 = P).
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - controlador_multiplicador_display_if.slave
//                   (load, a_in in; ready, done, product, seg, an out)
// Params  : FACTOR   (1..3)  constant multiplier
//           SCAN_DIV (>=1)   clock cycles each digit stays enabled
// Macro   : LEADING_ZERO_BLANK_EN - when defined, a tens digit equal to 0
//           is blanked (seg = 0); an timing is unaffected.
// -----------------------------------------------------------------------------
module controlador_multiplicador_display #(
    parameter int FACTOR   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    controlador_multiplicador_display_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MULT   = 2'd1;
    localparam logic [1:0] CONV   = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    localparam int              CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [1:0]      MULT_LAST = 2'(FACTOR - 1);

    generate
        if (FACTOR < 1 || FACTOR > 3) begin : g_bad_factor
            $error("FACTOR must be in the range 1..3");
        end
        if (SCAN_DIV < 1) begin : g_bad_scan_div
            $error("SCAN_DIV must be at least 1");
        end
    endgenerate

    // One double-dabble iteration on {tens, units, 7-bit binary}:
    // correct each BCD nibble >= 5 by +3, then shift left by one.
    function automatic logic [14:0] dabble_step(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[14:11] >= 4'd5) begin
            t[14:11] = t[14:11] + 4'd3;
        end else begin
            t[14:11] = t[14:11];
        end
        if (t[10:7] >= 4'd5) begin
            t[10:7] = t[10:7] + 4'd3;
        end else begin
            t[10:7] = t[10:7];
        end
        return {t[13:0], 1'b0};
    endfunction

    // Decimal digit to active-high {a,b,c,d,e,f,g}; non-decimal nibbles go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [1:0]       state_r;
    logic [4:0]       op_r;
    logic [6:0]       acc_r;
    logic [1:0]       mult_cnt_r;
    logic [2:0]       conv_cnt_r;
    logic [14:0]      sh_a_r;
    logic [14:0]      sh_p_r;
    logic [3:0][3:0]  dig_r;      // [0]=units A, [1]=tens A, [2]=units P, [3]=tens P
    logic [6:0]       product_r;
    logic             done_r;

    logic [CW-1:0]    scan_cnt_r;
    logic [1:0]       scan_idx_r;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;

    logic [6:0]       sum_s;
    logic             scan_wrap_s;
    logic [1:0]       scan_idx_nxt_s;
    logic [3:0]       nibble_s;
    logic [6:0]       seg_nxt_s;
    logic [3:0]       an_nxt_s;

    assign sum_s       = acc_r + {2'b00, op_r};
    assign scan_wrap_s = (scan_cnt_r == SCAN_LAST);

    // Controller FSM: capture, repeated addition, BCD conversion, result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            op_r       <= 5'd0;
            acc_r      <= 7'd0;
            mult_cnt_r <= 2'd0;
            conv_cnt_r <= 3'd0;
            sh_a_r     <= 15'd0;
            sh_p_r     <= 15'd0;
            dig_r      <= 16'd0;
            product_r  <= 7'd0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.load) begin
                        op_r       <= bus.a_in;
                        acc_r      <= 7'd0;
                        mult_cnt_r <= 2'd0;
                        state_r    <= MULT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                MULT: begin
                    acc_r      <= sum_s;
                    mult_cnt_r <= mult_cnt_r + 2'd1;
                    if (mult_cnt_r == MULT_LAST) begin
                        // Seed both converters with the final sum and the operand.
                        sh_p_r     <= {8'd0, sum_s};
                        sh_a_r     <= {10'd0, op_r};
                        conv_cnt_r <= 3'd0;
                        state_r    <= CONV;
                    end else begin
                        state_r    <= MULT;
                    end
                end
                CONV: begin
                    sh_p_r     <= dabble_step(sh_p_r);
                    sh_a_r     <= dabble_step(sh_a_r);
                    conv_cnt_r <= conv_cnt_r + 3'd1;
                    if (conv_cnt_r == 3'd6) begin
                        state_r <= UPDATE;
                    end else begin
                        state_r <= CONV;
                    end
                end
                UPDATE: begin
                    dig_r[0]  <= sh_a_r[10:7];
                    dig_r[1]  <= sh_a_r[14:11];
                    dig_r[2]  <= sh_p_r[10:7];
                    dig_r[3]  <= sh_p_r[14:11];
                    product_r <= acc_r;
                    done_r    <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Next displayed digit: index advance on terminal count plus its segment code.
    always_comb begin
        scan_idx_nxt_s = scan_idx_r;
        if (scan_wrap_s) begin
            scan_idx_nxt_s = scan_idx_r + 2'd1;
        end else begin
            scan_idx_nxt_s = scan_idx_r;
        end
        nibble_s  = dig_r[scan_idx_nxt_s];
        seg_nxt_s = seg_decode(nibble_s);
`ifdef LEADING_ZERO_BLANK_EN
        // Odd indices are tens digits; a zero there is suppressed.
        if (scan_idx_nxt_s[0] && (nibble_s == 4'd0)) begin
            seg_nxt_s = 7'b0000000;
        end else begin
            seg_nxt_s = seg_decode(nibble_s);
        end
`endif
        an_nxt_s = 4'b0001 << scan_idx_nxt_s;
    end

    // Free-running scan engine; an and seg share one edge so digits never mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 2'd0;
            an_r       <= 4'b0001;
            seg_r      <= 7'b1111110;
        end else begin
            if (scan_wrap_s) begin
                scan_cnt_r <= '0;
            end else begin
                scan_cnt_r <= scan_cnt_r + CW'(1);
            end
            scan_idx_r <= scan_idx_nxt_s;
            an_r       <= an_nxt_s;
            seg_r      <= seg_nxt_s;
        end
    end

    assign bus.ready   = (state_r == IDLE);
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.seg     = seg_r;
    assign bus.an      = an_r;

endmodule

// File: tb/tb_controlador_multiplicador_display.sv
// -----------------------------------------------------------------------------
// tb_controlador_multiplicador_display
// Purpose : self-checking bench for controlador_multiplicador_display with
//           FACTOR=3, SCAN_DIV=2. Expected products, digits and segment codes
//           come from decimal arithmetic on the operand; latency from FACTOR+8.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_controlador_multiplicador_display;

    localparam int FACTOR   = 3;
    localparam int SCAN_DIV = 2;
    localparam int LATENCY  = FACTOR + 8;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic clk;
    logic rst_n;
    int   vec;
    int   errs;

    controlador_multiplicador_display_if dut_if ();

    controlador_multiplicador_display #(
        .FACTOR   (FACTOR),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: segment code of display index idx for operand a.
    function automatic logic [6:0] model_seg(input int idx, input int a);
        int p;
        int val;
        p = a * FACTOR;
        case (idx)
            0:       val = a % 10;
            1:       val = a / 10;
            2:       val = p % 10;
            default: val = p / 10;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == 1 || idx == 3) && val == 0) return 7'b0000000;
`endif
        return SEG_TBL[val];
    endfunction

    task automatic pulse_load(input logic [4:0] a);
        @(negedge clk);
        dut_if.load = 1'b1;
        dut_if.a_in = a;
        @(posedge clk);
        #1;
        dut_if.load = 1'b0;
        dut_if.a_in = 5'($urandom_range(31));
    endtask

    // Counts rising edges until done is seen (sampled at negedge); -1 on timeout.
    task automatic wait_done(input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (dut_if.done === 1'b1) begin
                cycles = i;
                return;
            end
        end
    endtask

    // Records the segment code seen for each enabled digit over one full scan.
    task automatic capture_display(output logic [3:0][6:0] segs, output int bad_an);
        segs   = '0;
        bad_an = 0;
        repeat (4 * SCAN_DIV) begin
            @(negedge clk);
            case (dut_if.an)
                4'b0001: segs[0] = dut_if.seg;
                4'b0010: segs[1] = dut_if.seg;
                4'b0100: segs[2] = dut_if.seg;
                4'b1000: segs[3] = dut_if.seg;
                default: bad_an++;
            endcase
        end
    endtask

    task automatic test_reset();
        #22;
        vec++; if (dut_if.ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", dut_if.ready); end
        vec++; if (dut_if.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", dut_if.done); end
        vec++; if (dut_if.product !== 7'd0) begin errs++; $display("FAIL reset_product: got %0d want 0", dut_if.product); end
        vec++; if (dut_if.an !== 4'b0001) begin errs++; $display("FAIL reset_an: got %b want 0001", dut_if.an); end
        vec++; if (dut_if.seg !== 7'b1111110) begin errs++; $display("FAIL reset_seg: got %b want 1111110", dut_if.seg); end
    endtask

    task automatic test_scan_sequence();
        logic [3:0] exp_an;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            exp_an = 4'b0001 << ((k / 2) % 4);
            vec++;
            if (dut_if.an !== exp_an) begin
                errs++; $display("FAIL scan_seq[%0d]: got %b want %b", k, dut_if.an, exp_an);
            end
        end
    endtask

    task automatic test_a31();
        int cyc; int bad; logic [3:0][6:0] segs;
        pulse_load(5'd31);
        @(negedge clk);
        vec++; if (dut_if.ready !== 1'b0) begin errs++; $display("FAIL a31_ready_busy: got %b want 0", dut_if.ready); end
        wait_done(40, cyc);
        vec++; if (cyc !== LATENCY) begin errs++; $display("FAIL a31_latency: got %0d want %0d", cyc, LATENCY); end
        vec++; if (dut_if.product !== 7'd93) begin errs++; $display("FAIL a31_product: got %0d want 93", dut_if.product); end
        @(negedge clk);
        vec++; if (dut_if.done !== 1'b0) begin errs++; $display("FAIL a31_done_width: got %b want 0", dut_if.done); end
        capture_display(segs, bad);
        vec++; if (bad !== 0) begin errs++; $display("FAIL a31_an_onehot: got %0d bad want 0", bad); end
        for (int d = 0; d < 4; d++) begin
            vec++;
            if (segs[d] !== model_seg(d, 31)) begin
                errs++; $display("FAIL a31_digit[%0d]: got %b want %b", d, segs[d], model_seg(d, 31));
            end
        end
    endtask

    task automatic test_reset_midop();
        pulse_load(5'd17);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec++; if (dut_if.ready !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b want 1", dut_if.ready); end
        vec++; if (dut_if.done !== 1'b0) begin errs++; $display("FAIL midrst_done: got %b want 0", dut_if.done); end
        vec++; if (dut_if.product !== 7'd0) begin errs++; $display("FAIL midrst_product: got %0d want 0", dut_if.product); end
        vec++; if (dut_if.an !== 4'b0001) begin errs++; $display("FAIL midrst_an: got %b want 0001", dut_if.an); end
        vec++; if (dut_if.seg !== 7'b1111110) begin errs++; $display("FAIL midrst_seg: got %b want 1111110", dut_if.seg); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int cyc; int bad; logic [3:0][6:0] segs;
        pulse_load(5'd0);
        wait_done(40, cyc);
        vec++; if (cyc !== LATENCY) begin errs++; $display("FAIL zero_latency: got %0d want %0d", cyc, LATENCY); end
        vec++; if (dut_if.product !== 7'd0) begin errs++; $display("FAIL zero_product: got %0d want 0", dut_if.product); end
        @(negedge clk);
        vec++; if (dut_if.done !== 1'b0) begin errs++; $display("FAIL zero_done_width: got %b want 0", dut_if.done); end
        capture_display(segs, bad);
        for (int d = 0; d < 4; d++) begin
            vec++;
            if (segs[d] !== model_seg(d, 0)) begin
                errs++; $display("FAIL zero_digit[%0d]: got %b want %b", d, segs[d], model_seg(d, 0));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc; int bad; int extra; logic [3:0][6:0] segs;
        pulse_load(5'd10);
        @(posedge clk); #1;
        dut_if.load = 1'b1; dut_if.a_in = 5'd7;
        @(posedge clk); #1;                 // edge 2: FSM in MULT
        dut_if.load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dut_if.load = 1'b1; dut_if.a_in = 5'd7;
        @(posedge clk); #1;                 // edge 6: FSM in CONV
        dut_if.load = 1'b0;
        wait_done(40, cyc);
        vec++; if (cyc !== LATENCY - 6) begin errs++; $display("FAIL busy_latency: got %0d want %0d", cyc, LATENCY - 6); end
        vec++; if (dut_if.product !== 7'd30) begin errs++; $display("FAIL busy_product: got %0d want 30", dut_if.product); end
        capture_display(segs, bad);
        for (int d = 0; d < 4; d++) begin
            vec++;
            if (segs[d] !== model_seg(d, 10)) begin
                errs++; $display("FAIL busy_digit[%0d]: got %b want %b", d, segs[d], model_seg(d, 10));
            end
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (dut_if.done === 1'b1) extra++;
        end
        vec++; if (extra !== 0) begin errs++; $display("FAIL busy_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_reset_in_conv();
        int cyc; int bad; int extra; logic [3:0][6:0] segs;
        pulse_load(5'd20);
        repeat (6) @(posedge clk);          // 3 MULT + 3 CONV cycles
        #1 rst_n = 1'b0;
        #1;
        vec++; if (dut_if.ready !== 1'b1) begin errs++; $display("FAIL convrst_ready: got %b want 1", dut_if.ready); end
        vec++; if (dut_if.product !== 7'd0) begin errs++; $display("FAIL convrst_product: got %0d want 0", dut_if.product); end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (dut_if.done === 1'b1) extra++;
        end
        vec++; if (extra !== 0) begin errs++; $display("FAIL convrst_no_done: got %0d want 0", extra); end
        capture_display(segs, bad);
        for (int d = 0; d < 4; d++) begin
            vec++;
            if (segs[d] !== model_seg(d, 0)) begin
                errs++; $display("FAIL convrst_digit[%0d]: got %b want %b", d, segs[d], model_seg(d, 0));
            end
        end
        pulse_load(5'd2);
        wait_done(40, cyc);
        vec++; if (cyc !== LATENCY) begin errs++; $display("FAIL convrst_latency: got %0d want %0d", cyc, LATENCY); end
        vec++; if (dut_if.product !== 7'd6) begin errs++; $display("FAIL convrst_product2: got %0d want 6", dut_if.product); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int x;
        int y;
        x = $urandom_range(31);
        y = $urandom_range(31);
        @(negedge clk);
        dut_if.load = 1'b1;
        dut_if.a_in = 5'(x);
        @(posedge clk); #1;
        wait_done(40, cyc);
        vec++; if (cyc !== LATENCY) begin errs++; $display("FAIL b2b_latency1: got %0d want %0d", cyc, LATENCY); end
        vec++; if (dut_if.product !== 7'(x * FACTOR)) begin errs++; $display("FAIL b2b_product1: got %0d want %0d", dut_if.product, x * FACTOR); end
        dut_if.a_in = 5'(y);                // sampled in the IDLE cycle carrying done
        wait_done(40, cyc);
        vec++; if (cyc !== LATENCY + 1) begin errs++; $display("FAIL b2b_latency2: got %0d want %0d", cyc, LATENCY + 1); end
        vec++; if (dut_if.product !== 7'(y * FACTOR)) begin errs++; $display("FAIL b2b_product2: got %0d want %0d", dut_if.product, y * FACTOR); end
        dut_if.load = 1'b0;
        @(negedge clk);
        vec++; if (dut_if.ready !== 1'b1) begin errs++; $display("FAIL b2b_idle_after: got %b want 1", dut_if.ready); end
    endtask

    task automatic test_random();
        int cyc; int bad; int a; logic [3:0][6:0] segs;
        for (int n = 0; n < 12; n++) begin
            a = $urandom_range(31);
            repeat ($urandom_range(3)) @(negedge clk);
            pulse_load(5'(a));
            wait_done(40, cyc);
            vec++; if (cyc !== LATENCY) begin errs++; $display("FAIL rnd_latency a=%0d: got %0d want %0d", a, cyc, LATENCY); end
            vec++; if (dut_if.product !== 7'(a * FACTOR)) begin errs++; $display("FAIL rnd_product a=%0d: got %0d want %0d", a, dut_if.product, a * FACTOR); end
            @(negedge clk);
            vec++; if (dut_if.done !== 1'b0) begin errs++; $display("FAIL rnd_done_width a=%0d: got %b want 0", a, dut_if.done); end
            capture_display(segs, bad);
            vec++; if (bad !== 0) begin errs++; $display("FAIL rnd_an_onehot a=%0d: got %0d want 0", a, bad); end
            for (int d = 0; d < 4; d++) begin
                vec++;
                if (segs[d] !== model_seg(d, a)) begin
                    errs++; $display("FAIL rnd_digit[%0d] a=%0d: got %b want %b", d, a, segs[d], model_seg(d, a));
                end
            end
        end
    endtask

    initial begin
        vec         = 0;
        errs        = 0;
        rst_n       = 1'b0;
        dut_if.load = 1'b0;
        dut_if.a_in = 5'd0;
        test_reset();
        test_scan_sequence();
        test_a31();
        test_reset_midop();
        test_zero();
        test_busy_ignore();
        test_reset_in_conv();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
